// File: rtl/hud_pkg.sv
// Shared HUD definitions: life FSM states, default life/invulnerability
// constants and the heart-row thermometer encoder used by the life
// controller and by sprite rendering.
package hud_pkg;

    // Default number of hearts and lives restored on reset or restart.
    localparam int MAX_LIVES     = 3;

    // Default invulnerability window, in frames, after an accepted hit.
    localparam int INVULN_FRAMES = 60;

    // Width of the heart row on the HUD.
    localparam int HEART_SLOTS   = 3;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } life_state_t;

    // Thermometer code for the heart row: heart k+1 is filled while
    // lives > k; slots beyond the configured heart count stay empty.
    function automatic logic [HEART_SLOTS-1:0] heart_fill(
        input logic [1:0] lives,
        input int         max_lives
    );
        logic [HEART_SLOTS-1:0] fill;
        fill = '0;
        for (int k = 0; k < HEART_SLOTS; k++) begin
            if ((k < max_lives) && (int'(lives) > k)) begin
                fill[k] = 1'b1;
            end
        end
        return fill;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Frame tick generator: one-cycle pulse on each rising edge of the raw
// vertical-sync level. The pulse is combinational so it acts in the
// same cycle the new v_sync level is first seen.
module frame_tick (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_v_sync,
    output logic o_tick
);

    logic v_sync_q;

    // Remember last cycle's v_sync level; cleared so a frame is not
    // counted spuriously from stale history after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: clocked state is always assigned with <= so every register
        // samples the pre-edge values regardless of statement order.
        if (i_reset) begin
            v_sync_q <= 1'b0;
        end else begin
            v_sync_q <= i_v_sync;
        end
    end

    assign o_tick = i_v_sync & ~v_sync_q;

endmodule

// File: rtl/life_ctrl.sv
// Player life controller: tracks lives, runs the hit/invulnerability/
// death state machine paced by frame ticks, and drives the HUD heart
// row including blink during invulnerability. All outputs are
// registered and reflect the state produced by the previous edge.
module life_ctrl
    import hud_pkg::life_state_t, hud_pkg::ALIVE, hud_pkg::INVULN,
           hud_pkg::DEAD, hud_pkg::heart_fill;
#(
    parameter int MAX_LIVES     = hud_pkg::MAX_LIVES,
    parameter int INVULN_FRAMES = hud_pkg::INVULN_FRAMES,
    parameter int BLINK_BIT     = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_v_sync,
    input  logic       i_hit,
    input  logic       i_heal,
    input  logic       i_restart,
    output logic [1:0] o_lives,
    output logic [2:0] o_heart_fill,
    output logic       o_hud_visible,
    output logic       o_invuln,
    output logic       o_game_over,
    output logic       o_hit_ack
);

    localparam logic [1:0] LIVES_FULL = 2'(MAX_LIVES);
    localparam logic [7:0] CNT_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [2:0] FILL_FULL  = heart_fill(LIVES_FULL, MAX_LIVES);

    life_state_t state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit_ack_d;
    logic        tick;

    frame_tick u_frame_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_v_sync (i_v_sync),
        .o_tick   (tick)
    );

    // Next-state logic: restart beats hit beats heal; frame ticks only
    // count down an invulnerability window that was already running.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        hit_ack_d = 1'b0;

        if (i_restart) begin
            state_d = ALIVE;
            lives_d = LIVES_FULL;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (i_hit) begin
                        hit_ack_d = 1'b1;
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            cnt_d   = CNT_LOAD;
                            state_d = INVULN;
                        end else begin
                            lives_d = 2'd0;
                            state_d = DEAD;
                        end
                    end else if (i_heal && (lives_q < LIVES_FULL)) begin
                        lives_d = lives_q + 2'd1;
                    end
                end

                INVULN: begin
                    // A hit here is ignored but still swallows a same-cycle heal.
                    if (!i_hit && i_heal && (lives_q < LIVES_FULL)) begin
                        lives_d = lives_q + 2'd1;
                    end
                    if (tick) begin
                        if (cnt_q <= 8'd1) begin
                            cnt_d   = 8'd0;
                            state_d = ALIVE;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end

                DEAD: begin
                    // Only restart leaves DEAD.
                end

                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next
    // state so they line up with the state register after each edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ALIVE;
            lives_q       <= LIVES_FULL;
            cnt_q         <= 8'd0;
            o_heart_fill  <= FILL_FULL;
            o_hud_visible <= 1'b1;
            o_invuln      <= 1'b0;
            o_game_over   <= 1'b0;
            o_hit_ack     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            cnt_q         <= cnt_d;
            o_heart_fill  <= heart_fill(lives_d, MAX_LIVES);
            o_hud_visible <= (state_d == INVULN) ? cnt_d[BLINK_BIT] : 1'b1;
            o_invuln      <= (state_d == INVULN);
            o_game_over   <= (state_d == DEAD);
            o_hit_ack     <= hit_ack_d;
        end
    end

    assign o_lives = lives_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: a behavioural model pushes the
// expected outputs of every driven cycle into a scoreboard queue, which
// is popped and compared after the clock edge, plus directed checks of
// the key game scenarios.
module tb_life_ctrl;

    logic       i_clk;
    logic       i_reset;
    logic       i_v_sync;
    logic       i_hit;
    logic       i_heal;
    logic       i_restart;
    logic [1:0] o_lives;
    logic [2:0] o_heart_fill;
    logic       o_hud_visible;
    logic       o_invuln;
    logic       o_game_over;
    logic       o_hit_ack;

    typedef struct {
        logic [1:0] lives;
        logic [2:0] fill;
        logic       vis;
        logic       inv;
        logic       go;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: st 0 = alive, 1 = invulnerable, 2 = dead.
    int   m_lives;
    int   m_cnt;
    int   m_st;
    logic m_vs;

    life_ctrl #(
        .MAX_LIVES     (3),
        .INVULN_FRAMES (60),
        .BLINK_BIT     (3)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_v_sync      (i_v_sync),
        .i_hit         (i_hit),
        .i_heal        (i_heal),
        .i_restart     (i_restart),
        .o_lives       (o_lives),
        .o_heart_fill  (o_heart_fill),
        .o_hud_visible (o_hud_visible),
        .o_invuln      (o_invuln),
        .o_game_over   (o_game_over),
        .o_hit_ack     (o_hit_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = 3;
        m_cnt   = 0;
        m_st    = 0;
        m_vs    = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic h, input logic he,
                              input logic vs, output exp_t e);
        logic tk;
        logic ack;
        logic [7:0] cnt8;
        tk   = vs && !m_vs;
        m_vs = vs;
        ack  = 1'b0;
        if (r) begin
            m_lives = 3;
            m_cnt   = 0;
            m_st    = 0;
        end else if (m_st == 0) begin
            if (h) begin
                ack = 1'b1;
                if (m_lives == 1) begin
                    m_lives = 0;
                    m_st    = 2;
                end else begin
                    m_lives = m_lives - 1;
                    m_cnt   = 60;
                    m_st    = 1;
                end
            end else if (he && m_lives < 3) begin
                m_lives = m_lives + 1;
            end
        end else if (m_st == 1) begin
            if (!h && he && m_lives < 3) m_lives = m_lives + 1;
            if (tk) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_st = 0;
            end
        end
        cnt8    = 8'(m_cnt);
        e.lives = 2'(m_lives);
        e.fill  = 3'((1 << m_lives) - 1);
        e.vis   = (m_st == 1) ? cnt8[3] : 1'b1;
        e.inv   = (m_st == 1);
        e.go    = (m_st == 2);
        e.ack   = ack;
    endtask

    // One clock cycle of stimulus with scoreboard comparison afterwards.
    task automatic drive(input logic r, input logic h, input logic he, input logic vs);
        exp_t e;
        exp_t got;
        i_restart = r;
        i_hit     = h;
        i_heal    = he;
        i_v_sync  = vs;
        model_step(r, h, he, vs, e);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        i_restart = 1'b0;
        i_hit     = 1'b0;
        i_heal    = 1'b0;
        got = sb.pop_front();
        check("sb_lives", 8'(o_lives),       8'(got.lives));
        check("sb_fill",  8'(o_heart_fill),  8'(got.fill));
        check("sb_vis",   8'(o_hud_visible), 8'(got.vis));
        check("sb_inv",   8'(o_invuln),      8'(got.inv));
        check("sb_go",    8'(o_game_over),   8'(got.go));
        check("sb_ack",   8'(o_hit_ack),     8'(got.ack));
    endtask

    // Low cycle then high cycle: the second cycle carries the frame tick.
    task automatic frame(input logic hit_heal);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, hit_heal, hit_heal, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lives"}, 8'(o_lives),       8'd3);
        check({tag, "_fill"},  8'(o_heart_fill),  8'b111);
        check({tag, "_vis"},   8'(o_hud_visible), 8'd1);
        check({tag, "_inv"},   8'(o_invuln),      8'd0);
        check({tag, "_go"},    8'(o_game_over),   8'd0);
        check({tag, "_ack"},   8'(o_hit_ack),     8'd0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_v_sync  = 1'b0;
        i_hit     = 1'b0;
        i_heal    = 1'b0;
        i_restart = 1'b0;
        model_reset();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst");
        i_reset = 1'b0;

        // Hit in the first cycle after reset release.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit1_ack",   8'(o_hit_ack),     8'd1);
        check("hit1_lives", 8'(o_lives),       8'd2);
        check("hit1_fill",  8'(o_heart_fill),  8'b011);
        check("hit1_inv",   8'(o_invuln),      8'd1);
        check("hit1_vis",   8'(o_hud_visible), 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("ack_once", 8'(o_hit_ack), 8'd0);

        // Sixty frames; blink at 56/55, ignored hit+heal at tick 30.
        for (int t = 1; t <= 60; t++) begin
            frame(t == 30);
            if (t == 4)  check("blink_56", 8'(o_hud_visible), 8'd1);
            if (t == 5)  check("blink_55", 8'(o_hud_visible), 8'd0);
            if (t == 30) begin
                check("inv_hit_ack",   8'(o_hit_ack), 8'd0);
                check("inv_hit_lives", 8'(o_lives),   8'd2);
            end
            if (t == 59) check("inv_t59", 8'(o_invuln), 8'd1);
            if (t == 60) check("inv_t60", 8'(o_invuln), 8'd0);
        end

        // Heal to full, then heal saturates.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("heal_to3", 8'(o_lives), 8'd3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("heal_sat", 8'(o_lives), 8'd3);

        // Hit and heal together: hit wins.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check("hitheal_lives", 8'(o_lives),   8'd2);
        check("hitheal_ack",   8'(o_hit_ack), 8'd1);
        for (int t = 1; t <= 60; t++) frame(1'b0);

        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit2_lives", 8'(o_lives), 8'd1);
        for (int t = 1; t <= 60; t++) frame(1'b0);
        check("exp2_inv", 8'(o_invuln), 8'd0);

        // Final hit: game over.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("dead_lives", 8'(o_lives),      8'd0);
        check("dead_go",    8'(o_game_over),  8'd1);
        check("dead_fill",  8'(o_heart_fill), 8'b000);
        check("dead_ack",   8'(o_hit_ack),    8'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("dead_heal", 8'(o_lives), 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("dead_hit_ack", 8'(o_hit_ack), 8'd0);

        // Restart and hit together in DEAD: restart wins.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("rs_lives", 8'(o_lives),     8'd3);
        check("rs_go",    8'(o_game_over), 8'd0);
        check("rs_inv",   8'(o_invuln),    8'd0);
        check("rs_ack",   8'(o_hit_ack),   8'd0);

        // Restart aborts invulnerability.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b0);
        frame(1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("rs_inv_abort", 8'(o_invuln), 8'd0);
        check("rs_inv_lives", 8'(o_lives),  8'd3);

        // Reset asserted with 20 frames of invulnerability left.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) frame(1'b0);
        check("cnt20_inv", 8'(o_invuln),      8'd1);
        check("cnt20_vis", 8'(o_hud_visible), 8'd0);
        i_v_sync = 1'b0;
        i_reset  = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst_hold");
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_inv",   8'(o_invuln),  8'd0);
        check("post_rst_lives", 8'(o_lives),   8'd3);
        check("post_rst_ack",   8'(o_hit_ack), 8'd0);
        for (int t = 1; t <= 3; t++) frame(1'b0);
        check("post_rst_frames", 8'(o_invuln), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
